// File: rtl/binary_to_bcd_pkg.sv
// Shared definitions for the serial binary-to-BCD converter: the FSM state
// encoding and a helper that sizes the BCD result for a given binary width.
package binary_to_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Smallest number of decimal digits that can hold 2^width - 1 without loss.
  function automatic int min_digits(input int width);
    logic [63:0] max_value;
    int          digits;
    max_value = (64'd1 << width) - 64'd1;
    digits    = 1;
    for (int i = 0; i < 20; i++) begin
      if (max_value >= 64'd10) begin
        max_value = max_value / 64'd10;
        digits    = digits + 1;
      end
    end
    return digits;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: a digit of 5 or more gets 3
// added so that the following left shift carries correctly into the next digit.
module bcd_digit_adjust (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // Add 3 to any digit that would reach 10 or more after doubling.
  always_comb begin
    digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;
  end

endmodule

// File: rtl/binary_to_bcd_serial.sv
// Serial binary-to-BCD converter using the shift-and-add-3 (double dabble)
// algorithm, one bit per clock, with valid/ready handshakes on both sides.
module binary_to_bcd_serial
  import binary_to_bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_binary,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  // When the digit count covers every possible operand, the top adjusted bit
  // can never be set, so the overflow detector is left out entirely.
  localparam bit FITS = (DIGITS >= min_digits(WIDTH));

  state_t             state;
  logic [WIDTH-1:0]   operand;
  logic [BCD_W-1:0]   bcd;
  logic [BCD_W-1:0]   adjusted;
  logic [CNT_W-1:0]   count;
  logic               overflow;

  // One add-3 corrector per digit, all working on the current accumulator.
  for (genvar d = 0; d < DIGITS; d++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .digit_in  (bcd[4*d +: 4]),
      .digit_out (adjusted[4*d +: 4])
    );
  end

  assign out_bcd      = bcd;
  assign out_overflow = overflow;

  // Control FSM and datapath: capture, shift WIDTH times, then hold the result
  // until the consumer takes it. The final CONVERT cycle (count == 0) only
  // hands over to DONE, which gives WIDTH+1 edges from acceptance to out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      operand   <= '0;
      bcd       <= '0;
      overflow  <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            operand  <= in_binary;
            bcd      <= '0;
            overflow <= 1'b0;
            count    <= CNT_W'(WIDTH);
            in_ready <= 1'b0;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          if (count == '0) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            bcd     <= {adjusted[BCD_W-2:0], operand[WIDTH-1]};
            operand <= operand << 1;
            count   <= count - 1'b1;
            if (!FITS && adjusted[BCD_W-1]) begin
              overflow <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
